// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath: sequences IF/DEC/EX/MEM/WB per instruction,
// drives ALU opcode, mux selects and strobes, counts retired instructions and traps on illegals.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_src,
    output logic             instr_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StDec  = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StTrap = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'b100000;
    localparam logic [5:0] OpAddi  = 6'b110000;
    localparam logic [5:0] OpAndi  = 6'b110010;
    localparam logic [5:0] OpOri   = 6'b110011;
    localparam logic [5:0] OpLw    = 6'b000011;
    localparam logic [5:0] OpSw    = 6'b000111;
    localparam logic [5:0] OpBeq   = 6'b000000;
    localparam logic [5:0] OpBne   = 6'b000001;
    localparam logic [5:0] OpB     = 6'b111111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic func_ok, is_rtype, is_imm, is_lw, is_sw, is_beq, is_bne, is_b, legal;

    always_comb begin
        func_ok = 1'b0;
        case (func[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h8, 4'h9, 4'ha, 4'hc, 4'hd: func_ok = (func[5:4] == 2'b11);
            default:                     func_ok = 1'b0;
        endcase
    end

    assign is_rtype = (opcode == OpRtype) && func_ok;
    assign is_imm   = (opcode == OpAddi) || (opcode == OpAndi) || (opcode == OpOri);
    assign is_lw    = (opcode == OpLw);
    assign is_sw    = (opcode == OpSw);
    assign is_beq   = (opcode == OpBeq);
    assign is_bne   = (opcode == OpBne);
    assign is_b     = (opcode == OpB);
    assign legal    = is_rtype | is_imm | is_lw | is_sw | is_beq | is_bne | is_b;

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        alu_op      = AluAdd;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        instr_write = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        trap        = 1'b0;

        case (state_q)
            StIf: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    instr_write = 1'b1;
                    pc_write    = 1'b1;
                    state_d     = StDec;
                end
            end
            StDec: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = 2'b11;
                state_d   = legal ? StEx : StTrap;
            end
            StEx: begin
                if (is_rtype) begin
                    alu_src_a = 1'b1;
                    alu_op    = func[3:0];
                    state_d   = StWb;
                end else if (is_imm) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == OpAddi) ? AluAdd :
                                (opcode == OpAndi) ? AluAnd : AluOr;
                    state_d   = StWb;
                end else if (is_lw || is_sw) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = StMem;
                end else if (is_beq || is_bne) begin
                    alu_src_a = 1'b1;
                    alu_op    = AluSub;
                    pc_src    = 1'b1;
                    pc_write  = is_beq ? zero : ~zero;
                    retire    = 1'b1;
                    state_d   = StIf;
                end else if (is_b) begin
                    pc_src   = 1'b1;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = StIf;
                end else begin
                    state_d = StIf;
                end
            end
            StMem: begin
                i_or_d    = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (!is_lw && !is_sw) begin
                    state_d = StIf;
                end else if (mem_ready) begin
                    retire  = is_sw;
                    state_d = is_lw ? StWb : StIf;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                retire     = 1'b1;
                state_d    = StIf;
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StIf;
        endcase

        // Strobes must be quiet for the whole time reset is held, not just after the edge.
        if (!rst_n) begin
            retire      = 1'b0;
            alu_op      = AluAdd;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            instr_write = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            i_or_d      = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            trap        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIf;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-cycle output bundle and retire count are
// predicted from instruction class, wait counts and reset events.
module tb_multicycle_control;

    localparam int unsigned CntW = 4;

    localparam logic [2:0] SIf = 3'd0, SDec = 3'd1, SEx = 3'd2, SMem = 3'd3, SWb = 3'd4;
    localparam logic [2:0] STrap = 3'd5;

    localparam logic [9:0] FlPcw = 10'h200, FlPcs = 10'h100, FlIw  = 10'h080, FlMr  = 10'h040;
    localparam logic [9:0] FlMw  = 10'h020, FlIod = 10'h010, FlRw  = 10'h008, FlRd  = 10'h004;
    localparam logic [9:0] FlM2r = 10'h002, FlTr  = 10'h001, FlNone = 10'h000;

    localparam logic [5:0] OpR = 6'b100000, OpAddi = 6'b110000, OpAndi = 6'b110010;
    localparam logic [5:0] OpOri = 6'b110011, OpLw = 6'b000011, OpSw = 6'b000111;
    localparam logic [5:0] OpBeq = 6'b000000, OpBne = 6'b000001, OpB = 6'b111111;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [5:0]      opcode = '0, func = '0;
    logic            zero = 1'b0, mem_ready = 1'b0;
    logic [3:0]      alu_op;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            pc_write, pc_src, instr_write, mem_read, mem_write, i_or_d;
    logic            reg_write, reg_dst, mem_to_reg, trap;
    logic [2:0]      state;
    logic [CntW-1:0] retired;
    logic [19:0]     obs;

    int checks = 0;
    int errors = 0;
    int ret_model = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CntW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_src(pc_src), .instr_write(instr_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .trap(trap), .state(state), .retired(retired)
    );

    assign obs = {state, alu_op, alu_src_a, alu_src_b, pc_write, pc_src, instr_write,
                  mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, trap};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [2:0] st, input logic [3:0] aop,
                                       input logic sa, input logic [1:0] sb, input logic [9:0] fl);
        return {st, aop, sa, sb, fl};
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OpR) return fn[5:4] == 2'b11 && (fn[3:0] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                                              4'h8, 4'h9, 4'ha, 4'hc, 4'hd});
        return op inside {OpAddi, OpAndi, OpOri, OpLw, OpSw, OpBeq, OpBne, OpB};
    endfunction

    // One clock: drive inputs, compare bundle mid-cycle, advance past the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [19:0] exp);
        opcode = op; func = fn; zero = z; mem_ready = rdy;
        @(negedge clk);
        check_val(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic check_ret(input string tag);
        check_val(tag, 32'(retired), 32'(ret_model % (1 << CntW)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'($urandom);
        #1;
        check_val("rst_out", 32'(obs), 32'd0);
        ret_model = 0;
        check_ret("rst_cnt");
        @(negedge clk);
        check_val("rst_hold", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check_val("rst_edge", 32'(obs), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // zf: -1 random zero flag, else forced. Returns 1 if the instruction ended in reset/trap.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int ifw,
                             input int memw, input int zf, input bit abort_mem,
                             output bit stopped);
        logic       z;
        logic [3:0] aop;
        logic [9:0] mfl;
        stopped = 1'b0;
        for (int i = 0; i < ifw; i++)
            step("if_wait", 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                 mk(SIf, 4'd0, 1'b0, 2'b01, FlMr));
        step("if", 6'($urandom), 6'($urandom), 1'($urandom), 1'b1,
             mk(SIf, 4'd0, 1'b0, 2'b01, FlMr | FlIw | FlPcw));
        step("dec", op, fn, 1'($urandom), 1'($urandom), mk(SDec, 4'd0, 1'b0, 2'b11, FlNone));
        if (!is_legal(op, fn)) begin
            for (int i = 0; i < 20; i++)
                step("trap", 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                     mk(STrap, 4'd0, 1'b0, 2'b00, FlTr));
            check_ret("trap_cnt");
            stopped = 1'b1;
            return;
        end
        z = (zf < 0) ? 1'($urandom) : 1'(zf);
        if (op == OpR) begin
            step("ex_r", op, fn, z, 1'($urandom), mk(SEx, fn[3:0], 1'b1, 2'b00, FlNone));
            step("wb_r", op, fn, z, 1'($urandom), mk(SWb, 4'd0, 1'b0, 2'b00, FlRw | FlRd));
        end else if (op inside {OpAddi, OpAndi, OpOri}) begin
            aop = (op == OpAddi) ? 4'd0 : (op == OpAndi) ? 4'd2 : 4'd3;
            step("ex_i", op, fn, z, 1'($urandom), mk(SEx, aop, 1'b1, 2'b10, FlNone));
            step("wb_i", op, fn, z, 1'($urandom), mk(SWb, 4'd0, 1'b0, 2'b00, FlRw));
        end else if (op == OpLw || op == OpSw) begin
            mfl = FlIod | ((op == OpLw) ? FlMr : FlMw);
            step("ex_m", op, fn, z, 1'($urandom), mk(SEx, 4'd0, 1'b1, 2'b10, FlNone));
            for (int i = 0; i < memw; i++) begin
                step("mem_wait", op, fn, 1'($urandom), 1'b0, mk(SMem, 4'd0, 1'b0, 2'b00, mfl));
                if (abort_mem) begin
                    do_reset();
                    stopped = 1'b1;
                    return;
                end
            end
            step("mem", op, fn, 1'($urandom), 1'b1, mk(SMem, 4'd0, 1'b0, 2'b00, mfl));
            if (op == OpLw)
                step("wb_lw", op, fn, z, 1'($urandom), mk(SWb, 4'd0, 1'b0, 2'b00, FlRw | FlM2r));
        end else if (op == OpBeq || op == OpBne) begin
            mfl = FlPcs | (((op == OpBeq) ? z : !z) ? FlPcw : FlNone);
            step("ex_br", op, fn, z, 1'($urandom), mk(SEx, 4'd1, 1'b1, 2'b00, mfl));
        end else begin
            step("ex_b", op, fn, z, 1'($urandom), mk(SEx, 4'd0, 1'b0, 2'b00, FlPcs | FlPcw));
        end
        ret_model++;
        check_ret("retired");
    endtask

    logic [5:0] legal_ops [9];
    logic [3:0] alu_codes [10];

    initial begin
        bit         stp;
        logic [5:0] op, fn;
        legal_ops = '{OpR, OpAddi, OpAndi, OpOri, OpLw, OpSw, OpBeq, OpBne, OpB};
        alu_codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'ha, 4'hc, 4'hd};
        #2;
        do_reset();

        run_instr(OpR, 6'b110000, 0, 0, -1, 1'b0, stp);
        run_instr(OpLw, 6'($urandom), 0, 2, -1, 1'b0, stp);
        run_instr(OpSw, 6'($urandom), 0, 2, -1, 1'b0, stp);
        run_instr(OpBeq, 6'd0, 0, 0, 1, 1'b0, stp);
        run_instr(OpBeq, 6'd0, 0, 0, 0, 1'b0, stp);
        run_instr(OpBne, 6'd0, 0, 0, 0, 1'b0, stp);
        run_instr(OpB, 6'd0, 0, 0, 0, 1'b0, stp);

        run_instr(6'b101010, 6'd0, 0, 0, -1, 1'b0, stp);
        do_reset();
        run_instr(OpR, 6'b110111, 1, 0, -1, 1'b0, stp);
        do_reset();

        run_instr(OpSw, 6'd0, 0, 3, -1, 1'b1, stp);
        run_instr(OpR, 6'b110001, 0, 0, -1, 1'b0, stp);

        do_reset();
        for (int i = 0; i < 17; i++) run_instr(OpB, 6'($urandom), 0, 0, -1, 1'b0, stp);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 8) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
                fn = (op == OpR) ? {2'b11, alu_codes[$urandom_range(0, 9)]} : 6'($urandom);
            end
            run_instr(op, fn, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0, -1,
                      ($urandom_range(0, 99) < 3), stp);
            if (stp && trap) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
